// File: rtl/alsu_pkg.sv
// Shared constants and FSM encoding for the ALSU result serializer.
package alsu_pkg;

    // ALSU result word and FIFO entry ({err, res}) widths
    localparam int RES_W   = 6;
    localparam int ENTRY_W = RES_W + 1;

    // fifo_count width: holds 0..16 for the largest legal FIFO
    localparam int COUNT_W = 5;

    // Baud counter must cover CLKS_PER_BIT up to 255
    localparam int BAUD_W  = 8;

    // Bit counter indexes the six data bits
    localparam int BIT_W   = 3;

    // Serial frame lengths in bit periods
    localparam int FRAME_BITS     = 9;
    localparam int FRAME_BITS_PAR = 10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        ERR   = 3'd3,
        PAR   = 3'd4,
        STOP  = 3'd5
    } alsu_state_t;

endpackage

// File: rtl/alsu_res_fifo.sv
// Result FIFO: power-of-two depth, pointers wrap naturally.
// A push while full is accepted only when a pop happens on the same edge.
module alsu_res_fifo
    import alsu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [ENTRY_W-1:0] din,
    output logic [ENTRY_W-1:0] dout,
    output logic               full,
    output logic               empty,
    output logic [COUNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               push_ok;
    logic               pop_ok;

    assign full    = (count == COUNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    // Storage write; no reset needed since pointers define validity
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + COUNT_W'(1);
                2'b01:   count <= count - COUNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alsu_result_serializer.sv
// Buffers ALSU results and sends each as a UART-like frame:
// start(0), res[0..5] LSB first, err, optional even parity, stop(1).
//
// res_valid is a one-way strobe with no ready: an entry is taken whenever
// the FIFO has room (or is popped on the same edge); otherwise it is dropped
// and the sticky overflow flag records the loss until ovf_clr.
module alsu_result_serializer
    import alsu_pkg::*;
#(
    parameter int    CLKS_PER_BIT = 4,
    parameter int    FIFO_DEPTH   = 4,
    parameter string PARITY       = "OFF"
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [RES_W-1:0]   res_in,
    input  logic               res_valid,
    input  logic               err_in,
    input  logic               ovf_clr,
    output logic               tx_out,
    output logic               busy,
    output logic [COUNT_W-1:0] fifo_count,
    output logic               overflow
);

    localparam logic              PAR_EN    = (PARITY == "ON");
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(RES_W - 1);

    alsu_state_t        state, state_n;
    logic [BAUD_W-1:0]  baud_cnt, baud_n;
    logic [BIT_W-1:0]   bit_cnt, bit_n;
    logic [ENTRY_W-1:0] shift_q, shift_n;
    logic               par_q, par_n;
    logic               tx_n;
    logic               busy_n;
    logic               bit_done;
    logic               pop;
    logic               drop;
    logic [ENTRY_W-1:0] fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;

    alsu_res_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (res_valid),
        .pop   (pop),
        .din   ({err_in, res_in}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bit_done = (baud_cnt == BAUD_LAST);
    assign drop     = res_valid && fifo_full && !pop;

    // Next-state, counters, shifter and the next registered line value
    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_cnt;
        shift_n = shift_q;
        par_n   = par_q;
        pop     = 1'b0;
        tx_n    = 1'b1;
        busy_n  = 1'b0;

        if (state != IDLE) begin
            baud_n = bit_done ? '0 : baud_cnt + BAUD_W'(1);
        end

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = fifo_dout;
                    par_n   = ^fifo_dout;
                    state_n = START;
                    baud_n  = '0;
                    bit_n   = '0;
                end
            end
            START: begin
                if (bit_done) state_n = DATA;
            end
            DATA: begin
                // After the sixth shift the err bit sits at shift_q[0]
                if (bit_done) begin
                    shift_n = shift_q >> 1;
                    if (bit_cnt == BIT_LAST) begin
                        bit_n   = '0;
                        state_n = ERR;
                    end else begin
                        bit_n = bit_cnt + BIT_W'(1);
                    end
                end
            end
            ERR: begin
                if (bit_done) state_n = PAR_EN ? PAR : STOP;
            end
            PAR: begin
                if (bit_done) state_n = STOP;
            end
            STOP: begin
                if (bit_done) state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            ERR:     tx_n = shift_n[0];
            PAR:     tx_n = par_n;
            default: tx_n = 1'b1;
        endcase

        busy_n = (state_n != IDLE);
    end

    // FSM, counters, shifter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tx_out   <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            shift_q  <= shift_n;
            par_q    <= par_n;
            tx_out   <= tx_n;
            busy     <= busy_n;
        end
    end

    // Sticky overflow: a drop on the same edge as ovf_clr keeps it set
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule
